// File: rtl/uart_tx_fifo_if.sv
// Producer-side valid/ready word handshake for the buffered UART transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Data_valid;
  logic [WIDTH-1:0] Data;
  logic             Ready;

  modport master (output Data_valid, output Data, input Ready);
  modport slave  (input Data_valid, input Data, output Ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a DEPTH-word transmit FIFO, runtime prescaler,
// optional parity and one/two stop bits; frames are sent back-to-back.
module uart_tx_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         Parity_EN,
  input  logic                         Parity_type,
  input  logic                         Stop2,
  input  logic [PRESCALE_W-1:0]        Prescale,
  uart_tx_fifo_if.slave                bus,
  output logic [$clog2(DEPTH+1)-1:0]   Fifo_count,
  output logic                         Busy,
  output logic                         Tx_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_en;
  logic                  pop;
  logic                  fifo_nonempty;

  state_t                state;
  logic [PRESCALE_W-1:0] bit_cnt;
  logic [PRESCALE_W-1:0] prescale_q;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [WIDTH-1:0]      word_q;
  logic [WIDTH-1:0]      sh_q;
  logic                  pen_q;
  logic                  ptype_q;
  logic                  stop2_q;
  logic                  period_end;
  logic                  last_stop;

  assign bus.Ready     = (Fifo_count != CW'(DEPTH));
  assign wr_en         = bus.Data_valid && bus.Ready;
  assign fifo_nonempty = (Fifo_count != '0);

  // A bit period ends when the counter reaches the latched prescale minus one.
  assign period_end = (bit_cnt == (prescale_q - PRESCALE_W'(1)));
  assign last_stop  = period_end && (stop_idx == stop2_q);
  assign pop        = fifo_nonempty &&
                      ((state == IDLE) || ((state == STOP) && last_stop));

  // Pointers and occupancy; a write while full never reaches here (Ready low).
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Fifo_count <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   Fifo_count <= Fifo_count + CW'(1);
        2'b01:   Fifo_count <= Fifo_count - CW'(1);
        default: Fifo_count <= Fifo_count;
      endcase
    end
  end

  // Storage array, contents need no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= bus.Data;
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Tx_out     <= 1'b1;
      Busy       <= 1'b0;
      bit_cnt    <= '0;
      prescale_q <= PRESCALE_W'(1);
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      word_q     <= '0;
      sh_q       <= '0;
      pen_q      <= 1'b0;
      ptype_q    <= 1'b0;
      stop2_q    <= 1'b0;
    end else begin
      bit_cnt <= period_end ? '0 : bit_cnt + PRESCALE_W'(1);
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          Tx_out  <= 1'b1;
          Busy    <= 1'b0;
        end
        START: begin
          if (period_end) begin
            state   <= DATA;
            Tx_out  <= sh_q[0];
            sh_q    <= sh_q >> 1;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (period_end) begin
            if (bit_idx == BW'(WIDTH - 1)) begin
              if (pen_q) begin
                state  <= PARITY;
                Tx_out <= (^word_q) ^ ptype_q;
              end else begin
                state    <= STOP;
                Tx_out   <= 1'b1;
                stop_idx <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + BW'(1);
              Tx_out  <= sh_q[0];
              sh_q    <= sh_q >> 1;
            end
          end
        end
        PARITY: begin
          if (period_end) begin
            state    <= STOP;
            Tx_out   <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        STOP: begin
          if (last_stop) begin
            state  <= IDLE;
            Tx_out <= 1'b1;
            Busy   <= 1'b0;
          end else if (period_end) begin
            stop_idx <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          Tx_out <= 1'b1;
          Busy   <= 1'b0;
        end
      endcase

      // Popping a word overrides the above: latch the frame and start it.
      if (pop) begin
        state      <= START;
        Tx_out     <= 1'b0;
        Busy       <= 1'b1;
        bit_cnt    <= '0;
        word_q     <= mem[rd_ptr];
        sh_q       <= mem[rd_ptr];
        pen_q      <= Parity_EN;
        ptype_q    <= Parity_type;
        stop2_q    <= Stop2;
        prescale_q <= (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed and randomized bench for uart_tx_fifo, checked cycle by cycle
// against a queue-based line model of the transmitter.
module tb_uart_tx_fifo;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int PW = 8;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          Parity_EN;
  logic          Parity_type;
  logic          Stop2;
  logic [PW-1:0] Prescale;
  logic [2:0]    Fifo_count;
  logic          Busy;
  logic          Tx_out;

  uart_tx_fifo_if #(.WIDTH(W)) bus ();

  uart_tx_fifo #(.WIDTH(W), .DEPTH(D), .PRESCALE_W(PW)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .Parity_EN   (Parity_EN),
    .Parity_type (Parity_type),
    .Stop2       (Stop2),
    .Prescale    (Prescale),
    .bus         (bus),
    .Fifo_count  (Fifo_count),
    .Busy        (Busy),
    .Tx_out      (Tx_out)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Model: stored words and the per-cycle line levels of the frame on the wire.
  logic [W-1:0] mq[$];
  bit           lq[$];
  logic         exp_tx   = 1'b1;
  logic         exp_busy = 1'b0;
  logic         exp_rdy  = 1'b1;
  int           exp_cnt  = 0;
  int           busy_acc = 0;
  int           peak     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void build_frame(input logic [W-1:0] w);
    int p;
    bit bits[$];
    p = (Prescale == 0) ? 1 : int'(Prescale);
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(w[i]);
    if (Parity_EN) bits.push_back((($countones(w) % 2) == 1) ^ Parity_type);
    bits.push_back(1'b1);
    if (Stop2) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < p; k++) lq.push_back(bits[i]);
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  function automatic void model_step();
    bit wr;
    if (Reset) begin
      mq.delete();
      lq.delete();
    end else begin
      wr = bus.Data_valid && (mq.size() != D);
      if (lq.size() == 0 && mq.size() != 0) build_frame(mq.pop_front());
      if (wr) mq.push_back(bus.Data);
    end
    if (lq.size() != 0) begin
      exp_tx   = lq.pop_front();
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    exp_cnt = mq.size();
    exp_rdy = (mq.size() != D);
  endfunction

  task automatic cycle();
    model_step();
    @(posedge CLK);
    @(negedge CLK);
    check("tx", 32'(Tx_out), 32'(exp_tx));
    check("busy", 32'(Busy), 32'(exp_busy));
    check("ready", 32'(bus.Ready), 32'(exp_rdy));
    check("count", 32'(Fifo_count), 32'(exp_cnt));
    if (Busy) busy_acc++;
    if (int'(Fifo_count) > peak) peak = int'(Fifo_count);
  endtask

  task automatic run_idle(input int limit);
    bit done;
    done = 1'b0;
    for (int i = 0; i < limit; i++) begin
      cycle();
      if (!Busy && Fifo_count == 0) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    Reset          = 1'b1;
    Parity_EN      = 1'b0;
    Parity_type    = 1'b0;
    Stop2          = 1'b0;
    Prescale       = 8'd1;
    bus.Data_valid = 1'b0;
    bus.Data       = '0;
    repeat (2) @(negedge CLK);
    check("rst_tx", 32'(Tx_out), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_ready", 32'(bus.Ready), 32'd1);
    check("rst_count", 32'(Fifo_count), 32'd0);
    Reset = 1'b0;
    cycle();

    // Single A5 frame, even parity, one stop, 4-cycle bits.
    Parity_EN = 1'b1; Parity_type = 1'b0; Stop2 = 1'b0; Prescale = 8'd4;
    bus.Data = 8'hA5; bus.Data_valid = 1'b1;
    cycle();
    bus.Data_valid = 1'b0;
    check("t1_busy_before_pop", 32'(Busy), 32'd0);
    busy_acc = 0;
    run_idle(200);
    check("t1_busy_cycles", 32'(busy_acc), 32'd44);

    // Odd parity, two stops, prescale 1 and then 0.
    for (int k = 0; k < 2; k++) begin
      Parity_type = 1'b1; Stop2 = 1'b1; Prescale = (k == 0) ? 8'd1 : 8'd0;
      bus.Data = 8'hA5; bus.Data_valid = 1'b1;
      cycle();
      bus.Data_valid = 1'b0;
      busy_acc = 0;
      run_idle(100);
      check("t2_busy_cycles", 32'(busy_acc), 32'd12);
    end

    // Six consecutive writes into a depth-4 FIFO; the sixth is dropped.
    Parity_EN = 1'b0; Stop2 = 1'b0; Prescale = 8'd2;
    busy_acc = 0; peak = 0;
    for (int k = 0; k < 6; k++) begin
      bus.Data = 8'(8'h10 + k); bus.Data_valid = 1'b1;
      if (k == 5) check("t3_ready_full", 32'(bus.Ready), 32'd0);
      cycle();
    end
    bus.Data_valid = 1'b0;
    run_idle(400);
    check("t3_peak", 32'(peak), 32'd4);
    check("t3_busy_cycles", 32'(busy_acc), 32'd100);

    // Config change mid-frame only affects the next queued frame.
    Parity_EN = 1'b1; Parity_type = 1'b0; Prescale = 8'd4;
    busy_acc = 0;
    bus.Data = 8'h3C; bus.Data_valid = 1'b1; cycle();
    bus.Data = 8'hC3; cycle();
    bus.Data_valid = 1'b0;
    repeat (10) cycle();
    Parity_EN = 1'b0; Prescale = 8'd2;
    run_idle(400);
    check("t4_busy_cycles", 32'(busy_acc), 32'd64);

    // Write and pop on the same edge with two words stored.
    Prescale = 8'd1;
    busy_acc = 0;
    bus.Data_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.Data = 8'(8'h51 + k);
      cycle();
    end
    bus.Data_valid = 1'b0;
    for (int i = 0; i < 40 && lq.size() != 0; i++) cycle();
    check("t5_count_before", 32'(Fifo_count), 32'd2);
    bus.Data = 8'h99; bus.Data_valid = 1'b1;
    cycle();
    bus.Data_valid = 1'b0;
    check("t5_count_after", 32'(Fifo_count), 32'd2);
    run_idle(200);
    check("t5_busy_cycles", 32'(busy_acc), 32'd40);

    // Reset during the data bits with three words queued.
    Parity_EN = 1'b1; Prescale = 8'd4;
    bus.Data_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.Data = 8'(8'hE0 + k);
      cycle();
    end
    bus.Data_valid = 1'b0;
    repeat (8) cycle();
    check("t6_busy_pre", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("t6_rst_tx", 32'(Tx_out), 32'd1);
    check("t6_rst_busy", 32'(Busy), 32'd0);
    check("t6_rst_count", 32'(Fifo_count), 32'd0);
    repeat (2) cycle();
    Reset = 1'b0;
    busy_acc = 0;
    repeat (40) cycle();
    check("t6_no_residual", 32'(busy_acc), 32'd0);

    // Randomized traffic with occasional configuration changes.
    for (int i = 0; i < 500; i++) begin
      bus.Data_valid = 1'($urandom_range(0, 1));
      bus.Data       = 8'($urandom);
      if ($urandom_range(0, 15) == 0) begin
        Parity_EN   = 1'($urandom_range(0, 1));
        Parity_type = 1'($urandom_range(0, 1));
        Stop2       = 1'($urandom_range(0, 1));
        Prescale    = 8'($urandom_range(0, 3));
      end
      cycle();
    end
    bus.Data_valid = 1'b0;
    run_idle(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
